// File: rtl/line_fetch_sched.sv
// Line fetch scheduler: walks a frame line by line and issues DDR read bursts
// into the line FIFO whenever the FIFO has room for a full burst.
module line_fetch_sched #(
    parameter int BURST_BYTES      = 256,
    parameter int FIFO_DEPTH_WORDS = 128
) (
    input  logic        Bus2IP_Clk,
    input  logic        Bus2IP_Reset,
    input  logic        enable,
    input  logic        vsync,
    input  logic [31:0] frame_base_addr,
    input  logic [31:0] line_stride,
    input  logic [31:0] line_bytes,
    input  logic [15:0] num_lines,
    input  logic [7:0]  fifo_level,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic [11:0] rd_len,
    input  logic        rd_ack,
    input  logic        rd_done,
    output logic        busy,
    output logic        frame_done,
    output logic        sync_err,
    output logic        cfg_err
);

    localparam logic [31:0] ROOM_THR = 32'(FIFO_DEPTH_WORDS - BURST_BYTES / 4);
    localparam logic [31:0] BURST_W  = 32'(BURST_BYTES);
    localparam logic [11:0] BURST_L  = 12'(BURST_BYTES);

    typedef enum logic [2:0] {IDLE, WAIT_VSYNC, CHECK, REQ, WAIT_DONE, ADVANCE} state_t;

    state_t      r_state, w_nxt;
    logic [31:0] r_stride, r_line_bytes, r_line_addr, r_offset;
    logic [15:0] r_num_lines, r_line_cnt;
    logic        r_vsync_pend;
    logic        r_rd_req, r_frame_done, r_sync_err, r_cfg_err;
    logic [31:0] r_rd_addr;
    logic [11:0] r_rd_len;

    logic [31:0] w_rem, w_off_nxt;
    logic [15:0] w_cnt_nxt;
    logic [11:0] w_len;
    logic        w_eol, w_last, w_room, w_cfg_ok;
    logic        w_restart, w_start, w_adv, w_frame_done, w_sync_err, w_cfg_err;

    // Burst sizing and end-of-line / end-of-frame detection.
    assign w_rem     = r_line_bytes - r_offset;
    assign w_len     = (w_rem > BURST_W) ? BURST_L : w_rem[11:0];
    assign w_off_nxt = r_offset + {20'd0, r_rd_len};
    assign w_eol     = (w_off_nxt >= r_line_bytes);
    assign w_cnt_nxt = r_line_cnt + 16'd1;
    assign w_last    = w_eol && (w_cnt_nxt == r_num_lines);
    assign w_room    = ({24'd0, fifo_level} <= ROOM_THR);
    assign w_cfg_ok  = (line_bytes != 32'd0) && (num_lines != 16'd0);

    // Next-state logic; a restart request is resolved after the case so every
    // frame start (normal, resync, back-to-back) shares one config check.
    always_comb begin
        w_nxt        = r_state;
        w_restart    = 1'b0;
        w_start      = 1'b0;
        w_adv        = 1'b0;
        w_frame_done = 1'b0;
        w_sync_err   = 1'b0;
        w_cfg_err    = 1'b0;
        case (r_state)
            IDLE:       if (enable) w_nxt = WAIT_VSYNC;
            WAIT_VSYNC: begin
                if (!enable)    w_nxt = IDLE;
                else if (vsync) w_restart = 1'b1;
            end
            CHECK: begin
                if (!enable) w_nxt = IDLE;
                else if (vsync) begin
                    w_sync_err = 1'b1;
                    w_restart  = 1'b1;
                end else if (w_room) w_nxt = REQ;
            end
            REQ:        if (r_rd_req && rd_ack) w_nxt = WAIT_DONE;
            WAIT_DONE:  if (rd_done) w_nxt = ADVANCE;
            ADVANCE: begin
                if (!enable) w_nxt = IDLE;
                else if (r_vsync_pend || (vsync && !w_last)) begin
                    w_sync_err = 1'b1;
                    w_restart  = 1'b1;
                end else begin
                    w_adv = 1'b1;
                    if (w_last) begin
                        w_frame_done = 1'b1;
                        if (vsync) w_restart = 1'b1;
                        else       w_nxt = WAIT_VSYNC;
                    end else begin
                        w_nxt = CHECK;
                    end
                end
            end
            default:    w_nxt = IDLE;
        endcase
        if (w_restart) begin
            if (w_cfg_ok) begin
                w_start = 1'b1;
                w_nxt   = CHECK;
            end else begin
                w_cfg_err = 1'b1;
                w_nxt     = WAIT_VSYNC;
            end
        end
    end

    // State register.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) r_state <= IDLE;
        else              r_state <= w_nxt;
    end

    // Frame walk: shadow config at frame start, step offset/line in ADVANCE.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            r_stride     <= '0;
            r_line_bytes <= '0;
            r_num_lines  <= '0;
            r_line_addr  <= '0;
            r_offset     <= '0;
            r_line_cnt   <= '0;
        end else if (w_start) begin
            r_stride     <= line_stride;
            r_line_bytes <= line_bytes;
            r_num_lines  <= num_lines;
            r_line_addr  <= frame_base_addr;
            r_offset     <= '0;
            r_line_cnt   <= '0;
        end else if (w_adv) begin
            if (w_eol) begin
                r_offset    <= '0;
                r_line_addr <= r_line_addr + r_stride;
                r_line_cnt  <= w_cnt_nxt;
            end else begin
                r_offset <= w_off_nxt;
            end
        end
    end

    // Remember a vsync that lands while a burst is in flight.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) r_vsync_pend <= 1'b0;
        else if ((r_state == REQ || r_state == WAIT_DONE) && vsync) r_vsync_pend <= 1'b1;
        else if (r_state == ADVANCE || r_state == IDLE) r_vsync_pend <= 1'b0;
    end

    // Request outputs are captured once on the first REQ cycle and held until ack.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
            r_rd_len  <= '0;
        end else if (r_state == REQ) begin
            if (!r_rd_req) begin
                r_rd_req  <= 1'b1;
                r_rd_addr <= r_line_addr + r_offset;
                r_rd_len  <= w_len;
            end else if (rd_ack) begin
                r_rd_req <= 1'b0;
            end
        end
    end

    // Registered one-cycle status pulses.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_frame_done <= w_frame_done;
            r_sync_err   <= w_sync_err;
            r_cfg_err    <= w_cfg_err;
        end
    end

    assign rd_req     = r_rd_req;
    assign rd_addr    = r_rd_addr;
    assign rd_len     = r_rd_len;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;
    assign cfg_err    = r_cfg_err;

endmodule
